// File: rtl/isqrt_nr_pipe.sv
// isqrt_nr_pipe: pipelined y = floor(sqrt(x)), digit-by-digit restoring method, 16 iterations split over N_PIPE_STAGES stages.
// Ports: clk, rst (async, active-high), x_vld/x (32-bit operand in), y_vld/y (root out, bits [31:16] zero).
// Optional ISQRT_NR_PIPE_REMAINDER_EN adds rem (17-bit, x - y*y) from the last stage remainder.
// Each stage keeps only the operand bits later stages still consume, so operand registers shrink stage by stage.
module isqrt_nr_pipe #(
  parameter int N_PIPE_STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [31:0] y
`ifdef ISQRT_NR_PIPE_REMAINDER_EN
  ,
  output logic [16:0] rem
`endif
);
  localparam int K = 16 / N_PIPE_STAGES;
  localparam int L = N_PIPE_STAGES - 1;
  if (N_PIPE_STAGES != 1 && N_PIPE_STAGES != 2 && N_PIPE_STAGES != 4 &&
      N_PIPE_STAGES != 8 && N_PIPE_STAGES != 16) begin : g_bad
    $error("isqrt_nr_pipe: N_PIPE_STAGES must be 1, 2, 4, 8 or 16");
  end
  // Compare in 20 bits so the shifted remainder never loses its top bits.
  function automatic logic fits(input logic [17:0] r, input logic [15:0] q, input logic [1:0] b);
    return {r, b} >= {2'b00, q, 2'b01};
  endfunction
  function automatic logic [17:0] nxt_r(input logic [17:0] r, input logic [15:0] q, input logic [1:0] b);
    return 18'(fits(r, q, b) ? {r, b} - {2'b00, q, 2'b01} : {r, b});
  endfunction
  function automatic logic [15:0] nxt_q(input logic [17:0] r, input logic [15:0] q, input logic [1:0] b);
    return {q[14:0], fits(r, q, b)};
  endfunction
  for (genvar s = 0; s < N_PIPE_STAGES; s++) begin : g_st
    localparam int WI = 32 - 2 * K * s;
    localparam int WO = WI - 2 * K;
    logic [WI-1:0] xi;
    logic          vi;
    logic [17:0]   rc [K];
    logic [15:0]   qc [K];
    logic          v;
    logic [15:0]   q;
    if (s == 0) begin : g_in
      assign xi    = x;
      assign vi    = x_vld;
      assign rc[0] = '0;
      assign qc[0] = '0;
    end else begin : g_in
      assign xi    = g_st[s-1].g_x.xs;
      assign vi    = g_st[s-1].v;
      assign rc[0] = g_st[s-1].g_r.r;
      assign qc[0] = g_st[s-1].q;
    end
    for (genvar k = 1; k < K; k++) begin : g_it
      assign rc[k] = nxt_r(rc[k-1], qc[k-1], xi[WI-1-2*(k-1) -: 2]);
      assign qc[k] = nxt_q(rc[k-1], qc[k-1], xi[WI-1-2*(k-1) -: 2]);
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) v <= 1'b0;
      else v <= vi;
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (vi) q <= nxt_q(rc[K-1], qc[K-1], xi[WO+1:WO]);
    if (WO > 0) begin : g_x
      logic [WO-1:0] xs;
      always_ff @(posedge clk or posedge rst)
        if (rst) xs <= '0;
        else if (vi) xs <= xi[WO-1:0];
    end
    if (s < L) begin : g_r
      logic [17:0] r;
      always_ff @(posedge clk or posedge rst)
        if (rst) r <= '0;
        else if (vi) r <= nxt_r(rc[K-1], qc[K-1], xi[WO+1:WO]);
    end
  end
  assign y     = {16'b0, g_st[L].q};
  assign y_vld = g_st[L].v;
`ifdef ISQRT_NR_PIPE_REMAINDER_EN
  // Final remainder is at most 2*y, so 17 bits always hold it.
  always_ff @(posedge clk or posedge rst)
    if (rst) rem <= '0;
    else if (g_st[L].vi) rem <= 17'(nxt_r(g_st[L].rc[K-1], g_st[L].qc[K-1], g_st[L].xi[1:0]));
`endif
endmodule
